// File: rtl/axi_rd_arbiter.sv
// Two-master, one-slave AXI4 read-channel arbiter.
// Grants one read burst at a time (round-robin on contention), forwards the AR
// channel of the granted master to the slave, routes R beats back to it, and
// raises a sticky error on beat-count / rlast mismatches or stray R beats.
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   m0_*/m1_* AR inputs    read address channel from each master
//   m0_*/m1_* R outputs    read data channel back to each master
//   s_ar* / s_r*           shared slave read port
//   grant                  current/last granted master index
//   busy                   arbiter is holding a burst (not IDLE)
//   err                    sticky protocol error
module axi_rd_arbiter #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 64,
  parameter int unsigned IDW = 4
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic [AW-1:0]  m0_araddr,
  input  logic [IDW-1:0] m0_arid,
  input  logic [7:0]     m0_arlen,
  input  logic [2:0]     m0_arsize,
  input  logic [1:0]     m0_arburst,
  input  logic           m0_arvalid,
  output logic           m0_arready,
  output logic [IDW-1:0] m0_rid,
  output logic [DW-1:0]  m0_rdata,
  output logic [1:0]     m0_rresp,
  output logic           m0_rlast,
  output logic           m0_rvalid,
  input  logic           m0_rready,
  input  logic [AW-1:0]  m1_araddr,
  input  logic [IDW-1:0] m1_arid,
  input  logic [7:0]     m1_arlen,
  input  logic [2:0]     m1_arsize,
  input  logic [1:0]     m1_arburst,
  input  logic           m1_arvalid,
  output logic           m1_arready,
  output logic [IDW-1:0] m1_rid,
  output logic [DW-1:0]  m1_rdata,
  output logic [1:0]     m1_rresp,
  output logic           m1_rlast,
  output logic           m1_rvalid,
  input  logic           m1_rready,
  output logic [AW-1:0]  s_araddr,
  output logic [IDW-1:0] s_arid,
  output logic [7:0]     s_arlen,
  output logic [2:0]     s_arsize,
  output logic [1:0]     s_arburst,
  output logic           s_arvalid,
  input  logic           s_arready,
  input  logic [IDW-1:0] s_rid,
  input  logic [DW-1:0]  s_rdata,
  input  logic [1:0]     s_rresp,
  input  logic           s_rlast,
  input  logic           s_rvalid,
  output logic           s_rready,
  output logic           grant,
  output logic           busy,
  output logic           err
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  state_t     r_state, w_state_nxt;
  logic       r_grant, w_grant_nxt;
  logic       r_last_grant, w_last_grant_nxt;
  logic       r_err, w_err_nxt;
  logic [7:0] r_beat_cnt, w_beat_cnt_nxt;
  logic [7:0] r_len, w_len_nxt;

  // State and bookkeeping registers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_err        <= 1'b0;
      r_beat_cnt   <= 8'd0;
      r_len        <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_err        <= w_err_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
      r_len        <= w_len_nxt;
    end
  end

  // Next-state logic and channel routing
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_err_nxt        = r_err;
    w_beat_cnt_nxt   = r_beat_cnt;
    w_len_nxt        = r_len;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rid     = '0;
    m0_rdata   = '0;
    m0_rresp   = 2'b00;
    m0_rlast   = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rid     = '0;
    m1_rdata   = '0;
    m1_rresp   = 2'b00;
    m1_rlast   = 1'b0;
    m1_rvalid  = 1'b0;
    s_araddr   = '0;
    s_arid     = '0;
    s_arlen    = 8'd0;
    s_arsize   = 3'd0;
    s_arburst  = 2'd0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Stray R beat with no burst outstanding: refused and flagged
        if (s_rvalid) w_err_nxt = 1'b1;
        if (m0_arvalid || m1_arvalid) begin
          w_grant_nxt = (m0_arvalid && m1_arvalid) ? ~r_last_grant : m1_arvalid;
          w_state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (s_rvalid) w_err_nxt = 1'b1;
        if (r_grant) begin
          s_araddr   = m1_araddr;
          s_arid     = m1_arid;
          s_arlen    = m1_arlen;
          s_arsize   = m1_arsize;
          s_arburst  = m1_arburst;
          s_arvalid  = m1_arvalid;
          m1_arready = s_arready;
        end else begin
          s_araddr   = m0_araddr;
          s_arid     = m0_arid;
          s_arlen    = m0_arlen;
          s_arsize   = m0_arsize;
          s_arburst  = m0_arburst;
          s_arvalid  = m0_arvalid;
          m0_arready = s_arready;
        end
        if (s_arvalid && s_arready) begin
          w_len_nxt      = s_arlen;
          w_beat_cnt_nxt = 8'd0;
          w_state_nxt    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_grant) begin
          m1_rid    = s_rid;
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
          m1_rlast  = s_rlast;
          m1_rvalid = s_rvalid;
          s_rready  = m1_rready;
        end else begin
          m0_rid    = s_rid;
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
          m0_rlast  = s_rlast;
          m0_rvalid = s_rvalid;
          s_rready  = m0_rready;
        end
        if (s_rvalid && s_rready) begin
          w_beat_cnt_nxt = r_beat_cnt + 8'd1;
          // rlast must coincide exactly with the arlen-th beat
          if (s_rlast != (r_beat_cnt == r_len)) w_err_nxt = 1'b1;
          if (s_rlast) begin
            w_last_grant_nxt = r_grant;
            w_state_nxt      = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign grant = r_grant;
  assign busy  = (r_state != ST_IDLE);
  assign err   = r_err;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter.
module tb_axi_rd_arbiter;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 64;
  localparam int unsigned IDW = 4;

  logic           aclk, aresetn;
  logic [AW-1:0]  m0_araddr, m1_araddr, s_araddr;
  logic [IDW-1:0] m0_arid, m1_arid, s_arid;
  logic [7:0]     m0_arlen, m1_arlen, s_arlen;
  logic [2:0]     m0_arsize, m1_arsize, s_arsize;
  logic [1:0]     m0_arburst, m1_arburst, s_arburst;
  logic           m0_arvalid, m1_arvalid, s_arvalid;
  logic           m0_arready, m1_arready, s_arready;
  logic [IDW-1:0] m0_rid, m1_rid, s_rid;
  logic [DW-1:0]  m0_rdata, m1_rdata, s_rdata;
  logic [1:0]     m0_rresp, m1_rresp, s_rresp;
  logic           m0_rlast, m1_rlast, s_rlast;
  logic           m0_rvalid, m1_rvalid, s_rvalid;
  logic           m0_rready, m1_rready, s_rready;
  logic           grant, busy, err;

  int n_cmp = 0;
  int n_bad = 0;

  axi_rd_arbiter #(.AW(AW), .DW(DW), .IDW(IDW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen),
    .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid),
    .m0_arready(m0_arready), .m0_rid(m0_rid), .m0_rdata(m0_rdata),
    .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid),
    .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen),
    .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid),
    .m1_arready(m1_arready), .m1_rid(m1_rid), .m1_rdata(m1_rdata),
    .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid),
    .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
    .s_rready(s_rready),
    .grant(grant), .busy(busy), .err(err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Advance past the next rising edge; inputs change and outputs are sampled here
  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic clear_inputs();
    m0_araddr = '0; m0_arid = '0; m0_arlen = '0; m0_arsize = 3'd3; m0_arburst = 2'd1;
    m1_araddr = '0; m1_arid = '0; m1_arlen = '0; m1_arsize = 3'd3; m1_arburst = 2'd1;
    m0_arvalid = 0; m1_arvalid = 0; m0_rready = 0; m1_rready = 0;
    s_arready = 0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 0; s_rvalid = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_cmp++; if (grant !== 1'b0) begin n_bad++; $display("FAIL reset_grant got=%0b exp=0", grant); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%0b exp=0", err); end
    n_cmp++; if ({m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, s_rready} !== 6'b0) begin
      n_bad++; $display("FAIL reset_handshakes got=%b exp=000000",
                        {m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, s_rready}); end
    n_cmp++; if (m0_rdata !== 64'd0 || m1_rdata !== 64'd0) begin
      n_bad++; $display("FAIL reset_rdata got=%h/%h exp=0", m0_rdata, m1_rdata); end
  endtask

  task automatic test_single_m0();
    m0_araddr = 32'h8000_0000; m0_arlen = 8'd0; m0_arid = 4'h3; m0_arvalid = 1;
    #1;
    n_cmp++; if (m0_arready !== 1'b0) begin n_bad++; $display("FAIL single_idle_arready got=%0b exp=0", m0_arready); end
    tick();
    s_arready = 1;
    #1;
    n_cmp++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_0000 || s_arid !== 4'h3) begin
      n_bad++; $display("FAIL single_ar_fwd got=%0b/%h/%h exp=1/80000000/3", s_arvalid, s_araddr, s_arid); end
    n_cmp++; if (m0_arready !== 1'b1 || m1_arready !== 1'b0) begin
      n_bad++; $display("FAIL single_arready got=%0b%0b exp=10", m0_arready, m1_arready); end
    n_cmp++; if (busy !== 1'b1 || grant !== 1'b0) begin
      n_bad++; $display("FAIL single_addr_state got busy=%0b grant=%0b exp=1/0", busy, grant); end
    tick();
    m0_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 64'h1122_3344_5566_7788; s_rlast = 1; s_rid = 4'h3; m0_rready = 1;
    #1;
    n_cmp++; if (m0_rvalid !== 1'b1 || m0_rdata !== 64'h1122_3344_5566_7788 || m0_rlast !== 1'b1) begin
      n_bad++; $display("FAIL single_rbeat got=%0b/%h/%0b exp=1/1122334455667788/1", m0_rvalid, m0_rdata, m0_rlast); end
    n_cmp++; if (m1_rvalid !== 1'b0 || m1_rdata !== 64'd0 || s_rready !== 1'b1) begin
      n_bad++; $display("FAIL single_other got m1_rvalid=%0b m1_rdata=%h s_rready=%0b exp=0/0/1", m1_rvalid, m1_rdata, s_rready); end
    tick();
    s_rvalid = 0; s_rlast = 0; m0_rready = 0;
    #1;
    n_cmp++; if (busy !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL single_done got busy=%0b err=%0b exp=0/0", busy, err); end
  endtask

  task automatic test_round_robin();
    logic exp_g;
    apply_reset();
    m0_arid = 4'h2; m1_arid = 4'h5; m0_arvalid = 1; m1_arvalid = 1;
    s_arready = 1; m0_rready = 1; m1_rready = 1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2) == 1;
      tick();
      #1;
      n_cmp++; if (grant !== exp_g || s_arid !== (exp_g ? 4'h5 : 4'h2)) begin
        n_bad++; $display("FAIL rr_grant burst=%0d got=%0b/%h exp=%0b", k, grant, s_arid, exp_g); end
      tick();
      s_rvalid = 1; s_rlast = 1; s_rdata = 64'(k);
      #1;
      n_cmp++; if ({m1_rvalid, m0_rvalid} !== (exp_g ? 2'b10 : 2'b01)) begin
        n_bad++; $display("FAIL rr_route burst=%0d got m1/m0 rvalid=%0b%0b exp_grant=%0b", k, m1_rvalid, m0_rvalid, exp_g); end
      tick();
      s_rvalid = 0; s_rlast = 0;
    end
    m0_arvalid = 0; m1_arvalid = 0;
    #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rr_err got=%0b exp=0", err); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] beats [4];
    logic [5:0] pat;
    int idx;
    beats[0] = 64'hA0A0_0000_0000_0001; beats[1] = 64'hB1B1_0000_0000_0002;
    beats[2] = 64'hC2C2_0000_0000_0003; beats[3] = 64'hD3D3_0000_0000_0004;
    pat = 6'b110011;
    idx = 0;
    tick();  // let round-robin test's final IDLE settle
    m1_araddr = 32'h0000_1000; m1_arlen = 8'd3; m1_arvalid = 1; s_arready = 1;
    tick();
    tick();
    m1_arvalid = 0; s_arready = 0;
    for (int c = 0; c < 6; c++) begin
      m1_rready = pat[c];
      s_rvalid = 1; s_rdata = beats[idx]; s_rlast = (idx == 3);
      #1;
      n_cmp++; if (s_rready !== m1_rready) begin
        n_bad++; $display("FAIL stall_rready cyc=%0d got=%0b exp=%0b", c, s_rready, m1_rready); end
      n_cmp++; if (m1_rvalid !== 1'b1 || m1_rdata !== beats[idx] || m1_rlast !== (idx == 3) || m0_rvalid !== 1'b0) begin
        n_bad++; $display("FAIL stall_beat cyc=%0d got=%h last=%0b exp=%h", c, m1_rdata, m1_rlast, beats[idx]); end
      if (pat[c]) idx++;
      tick();
    end
    s_rvalid = 0; s_rlast = 0; m1_rready = 0;
    #1;
    n_cmp++; if (busy !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL stall_done got busy=%0b err=%0b exp=0/0", busy, err); end
  endtask

  task automatic test_early_last();
    m0_arlen = 8'd3; m0_arvalid = 1; s_arready = 1; m0_rready = 1;
    tick();
    tick();
    m0_arvalid = 0; s_arready = 0;
    for (int b = 0; b < 3; b++) begin
      s_rvalid = 1; s_rlast = (b == 2); s_rdata = 64'(b);
      tick();
      if (b == 1) begin
        #1;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL early_err_premature got=%0b exp=0", err); end
      end
    end
    s_rvalid = 0; s_rlast = 0;
    #1;
    n_cmp++; if (err !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL early_err got err=%0b busy=%0b exp=1/0", err, busy); end
    m1_arlen = 8'd0; m1_arvalid = 1; s_arready = 1; m1_rready = 1;
    tick();
    #1;
    n_cmp++; if (grant !== 1'b1) begin n_bad++; $display("FAIL early_next_grant got=%0b exp=1", grant); end
    tick();
    m1_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rlast = 1; s_rdata = 64'hFEED;
    #1;
    n_cmp++; if (m1_rvalid !== 1'b1 || m1_rdata !== 64'hFEED) begin
      n_bad++; $display("FAIL early_next_beat got=%0b/%h exp=1/feed", m1_rvalid, m1_rdata); end
    tick();
    s_rvalid = 0; s_rlast = 0;
    #1;
    n_cmp++; if (err !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL early_sticky got err=%0b busy=%0b exp=1/0", err, busy); end
  endtask

  task automatic test_rvalid_idle();
    apply_reset();
    #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL idle_pre_err got=%0b exp=0", err); end
    s_rvalid = 1; m0_rready = 1; m1_rready = 1;
    #1;
    n_cmp++; if (s_rready !== 1'b0 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL idle_rvalid_block got s_rready=%0b m0=%0b m1=%0b exp=0", s_rready, m0_rvalid, m1_rvalid); end
    tick();
    s_rvalid = 0;
    tick();
    #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL idle_rvalid_err got=%0b exp=1", err); end
  endtask

  task automatic test_reset_mid_burst();
    clear_inputs();
    m0_arlen = 8'd3; m0_arvalid = 1; s_arready = 1; m0_rready = 1;
    tick();
    tick();
    m0_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = 64'h55;
    tick();
    aresetn = 0; s_rvalid = 0;
    tick();
    aresetn = 1;
    #1;
    n_cmp++; if (busy !== 1'b0 || err !== 1'b0 || grant !== 1'b0) begin
      n_bad++; $display("FAIL midrst_state got busy=%0b err=%0b grant=%0b exp=0/0/0", busy, err, grant); end
    n_cmp++; if ({m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, s_rready} !== 6'b0) begin
      n_bad++; $display("FAIL midrst_handshakes got=%b exp=000000",
                        {m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, s_rready}); end
    m1_araddr = 32'h0000_2000; m1_arlen = 8'd0; m1_arvalid = 1; s_arready = 1; m1_rready = 1;
    tick();
    #1;
    n_cmp++; if (grant !== 1'b1 || s_araddr !== 32'h0000_2000 || m1_arready !== 1'b1) begin
      n_bad++; $display("FAIL midrst_m1_ar got grant=%0b addr=%h arready=%0b exp=1/2000/1", grant, s_araddr, m1_arready); end
    tick();
    m1_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rlast = 1; s_rdata = 64'hCAFE_F00D;
    #1;
    n_cmp++; if (m1_rvalid !== 1'b1 || m1_rdata !== 64'hCAFE_F00D || m1_rlast !== 1'b1) begin
      n_bad++; $display("FAIL midrst_m1_beat got=%0b/%h/%0b exp=1/cafef00d/1", m1_rvalid, m1_rdata, m1_rlast); end
    tick();
    s_rvalid = 0; s_rlast = 0;
    #1;
    n_cmp++; if (busy !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL midrst_done got busy=%0b err=%0b exp=0/0", busy, err); end
  endtask

  initial begin
    aresetn = 1'b0;
    clear_inputs();
    test_reset();
    test_single_m0();
    test_round_robin();
    test_stall();
    test_early_last();
    test_rvalid_idle();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
